line_clear_scan: RTL

LINE_CLEAR_SCAN -- requirements
Module: line_clear_scan

---
 rtl/line_clear_scan_if.sv | 26 ++
 rtl/line_clear_scan.sv | 114 +++++++++++
 2 files changed

// File: rtl/line_clear_scan_if.sv
// Board-scan handshake and row read/write bus shared by the line-clear scanner
// (slave) and the game logic / board memory that drives it (master).
interface line_clear_scan_if #(
    parameter int unsigned COLS = 10
) ();
    logic            start;
    logic            busy;
    logic            done;
    logic [4:0]      rd_row;
    logic [COLS-1:0] rd_data;
    logic            wr_en;
    logic [4:0]      wr_row;
    logic [COLS-1:0] wr_data;
    logic            hit;
    logic [1:0]      lineCount;

    modport master (
        output start, rd_data,
        input  busy, done, rd_row, wr_en, wr_row, wr_data, hit, lineCount
    );

    modport slave (
        input  start, rd_data,
        output busy, done, rd_row, wr_en, wr_row, wr_data, hit, lineCount
    );
endinterface

// File: rtl/line_clear_scan.sv
// Bottom-up full-line detection and in-place board compaction after a piece locks.
// Optional LINE_CLEAR_TOTAL_EN adds a wrapping 10-bit running total of cleared lines.
module line_clear_scan #(
    parameter int unsigned ROWS = 20,
    parameter int unsigned COLS = 10
) (
    input  logic             clk,
    input  logic             rst,
    line_clear_scan_if.slave bus
`ifdef LINE_CLEAR_TOTAL_EN
    ,
    output logic [9:0]       total_lines
`endif
);
    typedef enum logic [1:0] {StIdle, StScan, StFill, StReport} state_e;

    localparam logic [4:0] LastRow = 5'(ROWS - 1);

    state_e     state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [4:0] cnt_q, cnt_d;
    logic       row_full;
    logic [4:0] cnt_upd;

    // Kept outside the main comb block so rd_row -> rd_data -> wr_* forms no loop.
    assign bus.rd_row = (state_q == StScan) ? row_q : 5'd0;
    assign row_full   = &bus.rd_data;
    assign cnt_upd    = cnt_q + {4'd0, row_full};

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        cnt_d         = cnt_q;
        bus.busy      = (state_q != StIdle);
        bus.done      = 1'b0;
        bus.hit       = 1'b0;
        bus.lineCount = 2'd0;
        bus.wr_en     = 1'b0;
        bus.wr_row    = 5'd0;
        bus.wr_data   = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    row_d   = LastRow;
                    cnt_d   = 5'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                cnt_d = cnt_upd;
                // Surviving rows drop by the number of full rows found below them.
                if (!row_full && (cnt_q != 5'd0)) begin
                    bus.wr_en   = 1'b1;
                    bus.wr_row  = row_q + cnt_q;
                    bus.wr_data = bus.rd_data;
                end
                if (row_q == 5'd0) begin
                    if (cnt_upd != 5'd0) begin
                        row_d   = cnt_upd - 5'd1;
                        state_d = StFill;
                    end else begin
                        state_d = StReport;
                    end
                end else begin
                    row_d = row_q - 5'd1;
                end
            end
            StFill: begin
                bus.wr_en  = 1'b1;
                bus.wr_row = row_q;
                if (row_q == 5'd0) begin
                    state_d = StReport;
                end else begin
                    row_d = row_q - 5'd1;
                end
            end
            StReport: begin
                bus.done = 1'b1;
                if (cnt_q != 5'd0) begin
                    bus.hit       = 1'b1;
                    bus.lineCount = (cnt_q >= 5'd3) ? 2'd3 : cnt_q[1:0];
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= 5'd0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef LINE_CLEAR_TOTAL_EN
    logic [9:0] total_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            total_q <= 10'd0;
        end else if (state_q == StReport) begin
            total_q <= total_q + {5'd0, cnt_q};
        end
    end

    assign total_lines = total_q;
`endif
endmodule
